// File: rtl/cache_mem_arbiter.sv
// Shares the single RAM port between icache and dcache; dcache wins in IDLE, a grant is held until RAM ACCESS.
// Latency: request seen in IDLE at edge k drives RAM enables from k+1; at least 2 cycles to completion, then an IDLE bubble.
// Backpressure: the requester sees wait=1 until ACCESS. `ARB_FAIRNESS_EN forces an icache grant after MAX_DSTREAK dcache completions.
module cache_mem_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT     = 255
`ifdef ARB_FAIRNESS_EN
    ,
    parameter int MAX_DSTREAK = 4
`endif
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              iREN,
    input  logic [ADDR_W-1:0] iaddr,
    output logic              iwait,
    output logic [DATA_W-1:0] iload,
    input  logic              dREN,
    input  logic              dWEN,
    input  logic [ADDR_W-1:0] daddr,
    input  logic [DATA_W-1:0] dstore,
    output logic              dwait,
    output logic [DATA_W-1:0] dload,
    output logic              ramREN,
    output logic              ramWEN,
    output logic [ADDR_W-1:0] ramaddr,
    output logic [DATA_W-1:0] ramstore,
    input  logic [DATA_W-1:0] ramload,
    input  logic [1:0]        ramstate,
    output logic              arb_err
);
    localparam logic [1:0] RAM_ACCESS = 2'd2;
    localparam logic [1:0] RAM_ERROR  = 2'd3;
    localparam logic [7:0] TMO        = 8'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        IGRANT = 2'd1,
        DGRANT = 2'd2
    } state_t;

    state_t     state;
    logic [7:0] tcnt;
    logic       dwr;
    logic       dreq;
    logic       dact;
    logic       gact;
    logic       idone;
    logic       ddone;
    logic       fair_force;
    logic       pick_i;

    assign dreq = dREN | dWEN;
    // A dcache grant is tied to the operation it was entered with; changing it counts as a drop.
    assign dact = dwr ? dWEN : (dREN & ~dWEN);
    assign gact = (state == IGRANT) ? iREN :
                  (state == DGRANT) ? dact : 1'b0;

    assign idone = (state == IGRANT) && iREN && (ramstate == RAM_ACCESS);
    assign ddone = (state == DGRANT) && dact && (ramstate == RAM_ACCESS);

`ifdef ARB_FAIRNESS_EN
    localparam logic [2:0] SMAX = 3'(MAX_DSTREAK);
    logic [2:0] streak;
    assign fair_force = (streak == SMAX);
`else
    assign fair_force = 1'b0;
`endif

    assign pick_i = iREN & (~dreq | fair_force);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state   <= IDLE;
            tcnt    <= '0;
            dwr     <= 1'b0;
            arb_err <= 1'b0;
`ifdef ARB_FAIRNESS_EN
            streak  <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    tcnt <= '0;
                    if (pick_i) begin
                        state <= IGRANT;
                    end else if (dreq) begin
                        state <= DGRANT;
                        dwr   <= dWEN;
                    end
                end
                default: begin
                    if (ramstate == RAM_ERROR) begin
                        arb_err <= 1'b1;
                        state   <= IDLE;
                        tcnt    <= '0;
                    end else if (!gact || ramstate == RAM_ACCESS) begin
                        state <= IDLE;
                        tcnt  <= '0;
`ifdef ARB_FAIRNESS_EN
                        // Streak saturates so a long icache-idle period cannot wrap it back to zero.
                        if (gact && state == DGRANT && streak != SMAX)
                            streak <= streak + 3'd1;
                        else if (gact && state == IGRANT)
                            streak <= '0;
`endif
                    end else if (tcnt == TMO) begin
                        arb_err <= 1'b1;
                        state   <= IDLE;
                        tcnt    <= '0;
                    end else begin
                        tcnt <= tcnt + 8'd1;
                    end
                end
            endcase
        end
    end

    always_comb begin
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        case (state)
            IGRANT: begin
                ramREN  = 1'b1;
                ramaddr = iaddr;
            end
            DGRANT: begin
                ramWEN   = dWEN;
                ramREN   = dREN & ~dWEN;
                ramaddr  = daddr;
                ramstore = dstore;
            end
            default: ;
        endcase
    end

    assign iwait = ~idone;
    assign dwait = ~ddone;
    assign iload = idone ? ramload : '0;
    assign dload = ddone ? ramload : '0;

endmodule
